// File: rtl/debouncer_multi.sv
// ---------------------------------------------------------------------------
// debouncer_multi
//   N-channel switch/key debouncer. Each channel synchronises its raw input
//   through two flops, then waits until the synchronised level has held for
//   STABLE_CNT ce-qualified clocks before the debounced level (dout) follows.
//   A one-clock rise or fall pulse marks each dout transition. any_change is
//   the OR of all pulses and is registered with them.
//
// Ports
//   clk         in   1     system clock, rising edge
//   rst         in   1     asynchronous reset, active-high
//   ce          in   1     count enable (prescaler tick); tie 1 to count every clock
//   din         in   N_CH  raw asynchronous inputs
//   dout        out  N_CH  debounced levels
//   rise        out  N_CH  1-cycle pulse when dout[i] goes 0->1
//   fall        out  N_CH  1-cycle pulse when dout[i] goes 1->0
//   any_change  out  1     OR of rise|fall, same cycle
// ---------------------------------------------------------------------------
module debouncer_multi #(
  parameter int   N_CH       = 2,
  parameter int   STABLE_CNT = 19,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] dout,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_change
);

  localparam int               CNT_W   = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Next-cycle pulse values of all channels, gathered for any_change.
  logic [N_CH-1:0] rise_nx_s;
  logic [N_CH-1:0] fall_nx_s;
  logic            any_change_r;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic             s1_r;
    logic             s2_r;
    logic             last_r;
    logic             dout_r;
    logic             rise_r;
    logic             fall_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             restart_s;
    logic             qualify_s;

    // Stability counter next value and qualification decision.
    always_comb begin
      restart_s = (s2_r != last_r);
      cnt_nx_s  = cnt_r;
      qualify_s = 1'b0;
      // A level change always restarts the count, even on a non-ce clock;
      // the counter saturates at CNT_MAX instead of wrapping.
      if (restart_s) begin
        cnt_nx_s = '0;
      end else if (ce && (cnt_r < CNT_MAX)) begin
        cnt_nx_s = cnt_r + CNT_ONE;
      end else begin
        cnt_nx_s = cnt_r;
      end
      // A restart on the edge the count would qualify takes priority.
      if (!restart_s && (cnt_r == CNT_MAX) && (dout_r != last_r)) begin
        qualify_s = 1'b1;
      end else begin
        qualify_s = 1'b0;
      end
    end

    assign rise_nx_s[gi] = qualify_s & last_r;
    assign fall_nx_s[gi] = qualify_s & ~last_r;

    // Per-channel synchroniser, counter, debounced level and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_r   <= RST_VAL;
        s2_r   <= RST_VAL;
        last_r <= RST_VAL;
        dout_r <= RST_VAL;
        cnt_r  <= '0;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
      end else begin
        s1_r  <= din[gi];
        s2_r  <= s1_r;
        cnt_r <= cnt_nx_s;
        if (restart_s) begin
          last_r <= s2_r;
        end else begin
          last_r <= last_r;
        end
        if (qualify_s) begin
          dout_r <= last_r;
        end else begin
          dout_r <= dout_r;
        end
        rise_r <= rise_nx_s[gi];
        fall_r <= fall_nx_s[gi];
      end
    end

    assign dout[gi] = dout_r;
    assign rise[gi] = rise_r;
    assign fall[gi] = fall_r;
  end

  // Summary pulse, registered in the same cycle as the per-channel pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_change_r <= 1'b0;
    end else begin
      any_change_r <= |(rise_nx_s | fall_nx_s);
    end
  end

  assign any_change = any_change_r;

endmodule
